// File: rtl/program_loader_if.sv
// Program loader bus: byte-stream load handshake, load status and CU fetch port.
//   master : drives load_start/in_valid/in_byte/fetch_en/fetch_addr (stream source + CU)
//   slave  : the loader; drives in_ready/busy/done/err/word_count/fetch_data/fetch_valid
interface program_loader_if #(
    parameter int AW = 5,
    parameter int IW = 19
);
    logic          load_start;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] fetch_data;
    logic          fetch_valid;

    modport master (
        output load_start, in_valid, in_byte, fetch_en, fetch_addr,
        input  in_ready, busy, done, err, word_count, fetch_data, fetch_valid
    );

    modport slave (
        input  load_start, in_valid, in_byte, fetch_en, fetch_addr,
        output in_ready, busy, done, err, word_count, fetch_data, fetch_valid
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a little-endian byte stream (3 bytes per word) into
// 19-bit instruction words, stores them in a DEPTH-entry single-port memory,
// then serves registered fetches to the control unit once loading is done.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - program_loader_if.slave (load handshake, status, fetch port)
// Word layout: opcode[18:15] op1[14:10] op2[9:5] op3[4:0]; opcode 0 is HALT.
module program_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 19
) (
    input  logic           clk,
    input  logic           rst,
    program_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B0   = 3'd1;
    localparam logic [2:0] S_B1   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] word_q, word_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          err_q, err_d;
    logic [IW-1:0] fetch_data_q, fetch_data_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          mem_we;
    logic          in_ready;
    logic          accept;

    logic [IW-1:0] mem [DEPTH];

    // in_ready decodes the state flop only, never in_valid
    assign in_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        word_count_d  = word_count_q;
        err_d         = err_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        mem_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d      = S_B0;
                    word_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_B0: begin
                if (accept) begin
                    word_d[7:0] = bus.in_byte;
                    state_d     = S_B1;
                end
            end
            S_B1: begin
                if (accept) begin
                    word_d[15:8] = bus.in_byte;
                    state_d      = S_B2;
                end
            end
            S_B2: begin
                if (accept) begin
                    // Unused high bits of the last byte mean the stream is
                    // misaligned: drop this word and stop the load.
                    if (|bus.in_byte[7:IW-16]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        word_d[IW-1:16] = bus.in_byte[IW-17:0];
                        state_d         = S_WR;
                    end
                end
            end
            S_WR: begin
                mem_we       = 1'b1;
                word_count_d = word_count_q + 1'b1;
                // HALT is stored and counted, then the load ends
                if (word_q[IW-1:IW-4] == 4'b0000 || word_count_d == DEPTH_W)
                    state_d = S_DONE;
                else
                    state_d = S_B0;
            end
            S_DONE: begin
                if (bus.fetch_en) begin
                    fetch_valid_d = 1'b1;
                    // Addresses past the loaded program read as HALT
                    if ({1'b0, bus.fetch_addr} < word_count_q)
                        fetch_data_d = mem[bus.fetch_addr];
                    else
                        fetch_data_d = '0;
                end
                if (bus.load_start) begin
                    state_d      = S_B0;
                    word_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_q        <= '0;
            word_count_q  <= '0;
            err_q         <= 1'b0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            word_count_q  <= word_count_d;
            err_q         <= err_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Contents are deliberately not reset; word_count=0 makes them unreachable
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[word_count_q[AW-1:0]] <= word_q;
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = in_ready || (state_q == S_WR);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = err_q;
    assign bus.word_count  = word_count_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int IW    = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_loader_if #(.AW(AW), .IW(IW)) bus ();

    program_loader #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: derived from the byte stream by the load rules
    logic [7:0]    stream [$];
    logic [IW-1:0] exp_mem [DEPTH];
    int            exp_cnt;
    logic          exp_err;
    int            exp_used;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [18:0] w);
        stream.push_back(w[7:0]);
        stream.push_back(w[15:8]);
        stream.push_back({5'b0, w[18:16]});
    endtask

    function automatic logic [18:0] rand_word(input int opc);
        logic [18:0] w;
        w = 19'($urandom);
        w[18:15] = 4'(opc);
        return w;
    endfunction

    // Walk the stream three bytes at a time and decide what gets stored.
    task automatic model_run();
        int i;
        exp_cnt  = 0;
        exp_err  = 1'b0;
        exp_used = 0;
        i = 0;
        while (i + 3 <= stream.size()) begin
            exp_used = i + 3;
            if ((stream[i+2] >> 3) != 0) begin
                exp_err = 1'b1;
                break;
            end
            exp_mem[exp_cnt] = {stream[i+2][2:0], stream[i+1], stream[i]};
            exp_cnt++;
            if (stream[i+2][2:0] == 3'd0 && stream[i+1][7] == 1'b0) break;
            if (exp_cnt == DEPTH) break;
            i += 3;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    // inject=1: pulse load_start and fetch_en while the FSM sits in B1
    task automatic load_stream(input int gap, input bit inject);
        logic [IW-1:0] prev;
        logic          seen;
        model_run();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("ready_after_start", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < exp_used; i++) begin
            if (inject && i == 1) begin
                prev = bus.fetch_data;
                bus.fetch_en   = 1'b1;
                bus.fetch_addr = '0;
                bus.load_start = 1'b1;
                tick();
                bus.fetch_en   = 1'b0;
                bus.load_start = 1'b0;
                chk("fetch_valid_in_b1", 32'(bus.fetch_valid), 32'd0);
                chk("fetch_data_hold_b1", 32'(bus.fetch_data), 32'(prev));
                chk("busy_in_b1", 32'(bus.busy), 32'd1);
            end
            send_byte(stream[i]);
            for (int g = 0; g < gap; g++) begin
                tick();
                if (i < exp_used - 1)
                    chk("busy_during_gap", 32'(bus.busy), 32'd1);
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("done_reached", 32'(seen), 32'd1);
        chk("word_count", 32'(bus.word_count), 32'(exp_cnt));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("busy_after_load", 32'(bus.busy), 32'd0);
        if (stream.size() > exp_used) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = stream[exp_used];
            chk("ready_in_done", 32'(bus.in_ready), 32'd0);
            tick();
            bus.in_valid = 1'b0;
            chk("count_after_extra", 32'(bus.word_count), 32'(exp_cnt));
        end
    endtask

    task automatic fetch_chk(input int addr);
        logic [IW-1:0] e;
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = AW'(addr);
        tick();
        bus.fetch_en   = 1'b0;
        e = (addr < exp_cnt) ? exp_mem[addr] : '0;
        chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
        chk($sformatf("fetch_data[%0d]", addr), 32'(bus.fetch_data), 32'(e));
    endtask

    task automatic verify_all();
        int last;
        last = (exp_cnt + 1 < DEPTH - 1) ? exp_cnt + 1 : DEPTH - 1;
        for (int a = 0; a <= last; a++) fetch_chk(a);
        tick();
        chk("fetch_valid_pulse", 32'(bus.fetch_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
        chk({tag, "_fetch_data"}, 32'(bus.fetch_data), 32'd0);
        chk({tag, "_fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_byte    = '0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // fetch in IDLE is not serviced
        bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
        chk("fetch_valid_idle", 32'(bus.fetch_valid), 32'd0);

        // Directed stream: first word already has opcode 0, so it ends the load
        stream.delete();
        stream = '{8'h3F, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        load_stream(0, 1'b0);
        verify_all();

        // Throttled random program: several non-HALT words then HALT
        stream.delete();
        n = $urandom_range(6, 2);
        for (int i = 0; i < n; i++) push_word(rand_word($urandom_range(15, 1)));
        push_word(rand_word(0));
        load_stream(3, 1'b0);
        verify_all();

        // Full memory: 32 words of opcode 1000, then one byte that must be refused
        stream.delete();
        for (int i = 0; i < DEPTH; i++) push_word(rand_word(8));
        stream.push_back(8'hA5);
        load_stream(0, 1'b0);
        for (int i = 0; i < 6; i++) fetch_chk($urandom_range(DEPTH - 1, 0));
        fetch_chk(DEPTH - 1);

        // Format error on the first word: nothing stored, address 0 reads HALT
        stream.delete();
        stream = '{8'h12, 8'h34, 8'h08};
        load_stream(0, 1'b0);
        fetch_chk(0);
        chk("done_after_err", 32'(bus.done), 32'd1);

        // load_start and fetch_en while in B1 are ignored
        stream.delete();
        push_word(rand_word($urandom_range(15, 1)));
        push_word(rand_word($urandom_range(15, 1)));
        push_word(rand_word(0));
        load_stream(1, 1'b1);
        verify_all();

        // Reset after four accepted bytes aborts the load
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h03);
        send_byte(8'h44);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midload_reset");
        rst = 1'b0;
        tick();
        stream.delete();
        stream = '{8'h55, 8'h2A, 8'h00};
        load_stream(0, 1'b0);
        fetch_chk(1);
        fetch_chk(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
